mul_div_unit: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle ALU's MUL/DIV/REM paths.
- Iterative radix-2 engine covering the RV64M and RV32M-W operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- Sits beside the ALU in execute. Decode steers M-extension ops here; the ALU keeps single-cycle ops.
- valid/ready on both sides, with tag passthrough and flush.

---
 rtl/mdu_pkg.sv | 50 +++++
 rtl/mdu_operand_prep.sv | 75 +++++++
 rtl/mul_div_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and op-classification helpers for the
// iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_word(input mdu_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_signed_a(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM,
                          OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_signed_b(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM,
                          OP_MULW, OP_DIVW, OP_REMW};
    endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Operand width selection, magnitude/sign extraction and
// special-case (div-by-zero, overflow, illegal) detection.
module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int W_OPS = 1
) (
    input  mdu_op_t           op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_q_o,
    output logic              neg_r_o,
    output logic              word_o,
    output logic              illegal_o,
    output logic              special_o,
    output logic [XLEN-1:0]   spec_res_o
);

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [XLEN-1:0] a_x;
    logic [XLEN-1:0] b_x;
    logic [XLEN-1:0] min_x;
    logic            sa;
    logic            sb;
    logic            sign_a;
    logic            sign_b;
    logic            div0;
    logic            ovf;

    // Select operand width, derive magnitudes and flag special cases
    always_comb begin
        word_o    = is_word(op_i);
        sa        = is_signed_a(op_i);
        sb        = is_signed_b(op_i);
        illegal_o = (op_i > OP_REMUW) || (word_o && (W_OPS == 0));
        a_x       = a_i;
        b_x       = b_i;
        min_x     = {1'b1, {(XLEN-1){1'b0}}};
        if (word_o) begin
            a_x   = sa ? sx32(a_i[31:0]) : XLEN'(a_i[31:0]);
            b_x   = sb ? sx32(b_i[31:0]) : XLEN'(b_i[31:0]);
            min_x = sx32(32'h8000_0000);
        end
        sign_a  = sa & a_x[XLEN-1];
        sign_b  = sb & b_x[XLEN-1];
        mag_a_o = sign_a ? -a_x : a_x;
        mag_b_o = sign_b ? -b_x : b_x;
        neg_q_o = sign_a ^ sign_b;
        neg_r_o = sign_a;
        div0    = is_div(op_i) && (b_x == '0);
        ovf     = is_div(op_i) && sa && (a_x == min_x) && (b_x == '1);
        special_o  = illegal_o || div0 || ovf;
        spec_res_o = '0;
        if (illegal_o) begin
            spec_res_o = '0;
        end else if (div0) begin
            if (is_rem(op_i))
                spec_res_o = word_o ? sx32(a_i[31:0]) : a_i;
            else
                spec_res_o = '1;
        end else if (ovf) begin
            spec_res_o = is_rem(op_i) ? '0 : a_x;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (RV64M + W ops)
// with valid/ready handshakes, tag passthrough and flush.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int W_OPS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  mdu_op_t          in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sx32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [XLEN-1:0] p_mag_a;
    logic [XLEN-1:0] p_mag_b;
    logic            p_neg_q;
    logic            p_neg_r;
    logic            p_word;
    logic            p_illegal;
    logic            p_special;
    logic [XLEN-1:0] p_spec_res;

    mdu_operand_prep #(
        .XLEN  (XLEN),
        .W_OPS (W_OPS)
    ) u_prep (
        .op_i       (in_op),
        .a_i        (in_a),
        .b_i        (in_b),
        .mag_a_o    (p_mag_a),
        .mag_b_o    (p_mag_b),
        .neg_q_o    (p_neg_q),
        .neg_r_o    (p_neg_r),
        .word_o     (p_word),
        .illegal_o  (p_illegal),
        .special_o  (p_special),
        .spec_res_o (p_spec_res)
    );

    // acc: product (mul) or partial remainder (div)
    // a:   shifted multiplicand (mul) or dividend/quotient (div)
    // b:   shifted multiplier (mul) or divisor (div)
    mdu_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mdu_op_t           op_q, op_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              ill_q, ill_d;

    logic [2*XLEN-1:0] mul_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   qv;
    logic [XLEN-1:0]   rv;
    logic [XLEN-1:0]   dv;
    logic [XLEN-1:0]   fix;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            ill_q   <= ill_d;
        end
    end

    // One radix-2 step, sign fix-up and next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        tag_d   = tag_q;
        ill_d   = ill_q;

        mul_acc = acc_q + (b_q[0] ? a_q : '0);
        rem_sh  = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff    = rem_sh - {1'b0, b_q};
        quo     = {a_q[XLEN-2:0], ~diff[XLEN]};
        rem_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

        prod = negq_q ? -mul_acc : mul_acc;
        qv   = negq_q ? -quo : quo;
        rv   = negr_q ? -rem_n : rem_n;
        dv   = is_rem(op_q) ? rv : qv;
        if (is_div(op_q))
            fix = is_word(op_q) ? sx32(dv[31:0]) : dv;
        else if (is_word(op_q))
            fix = sx32(prod[31:0]);
        else if (op_q == OP_MUL)
            fix = prod[XLEN-1:0];
        else
            fix = prod[2*XLEN-1:XLEN];

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = in_op;
                    tag_d  = in_tag;
                    negq_d = p_neg_q;
                    negr_d = p_neg_r;
                    ill_d  = p_illegal;
                    acc_d  = '0;
                    b_d    = p_mag_b;
                    if (p_word && is_div(in_op))
                        a_d = {{XLEN{1'b0}}, p_mag_a << (XLEN-32)};
                    else
                        a_d = {{XLEN{1'b0}}, p_mag_a};
                    if (p_special) begin
                        res_d   = p_spec_res;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = p_word ? CW'(31) : CW'(XLEN-1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (is_div(op_q)) begin
                    acc_d = {{XLEN{1'b0}}, rem_n};
                    a_d   = {{XLEN{1'b0}}, quo};
                end else begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    res_d   = fix;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush)
            state_d = S_IDLE;
    end

    assign in_ready    = (state_q == S_IDLE) && !flush;
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = res_q;
    assign out_tag     = tag_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit:
// results, latencies, handshake hold, flush, reset and illegal ops.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    mdu_op_t          in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int n_checks;
    int n_fail;

    mul_div_unit #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W),
        .W_OPS (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, measure latency, optionally consume result.
    task automatic issue(input mdu_op_t op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg,
                         input bit consume,
                         output logic [XLEN-1:0] res, output logic [TAG_W-1:0] rtag,
                         output logic ill, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tg;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res  = out_result;
        rtag = out_tag;
        ill  = out_illegal;
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (out_result !== '0) begin
            n_fail++;
            $display("FAIL reset_out_result: got %h expected 0", out_result);
        end
        n_checks++;
        if (out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_out_tag: got %h expected 0", out_tag);
        end
        n_checks++;
        if (out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_illegal: got %b expected 0", out_illegal);
        end
    endtask

    task automatic test_div();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_DIV, -64'sd7, 64'd2, 5'd3, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_result: got %h expected fffffffffffffffd", r);
        end
        n_checks++;
        if (lat !== 65) begin
            n_fail++;
            $display("FAIL div_latency: got %0d expected 65", lat);
        end
        n_checks++;
        if (t !== 5'd3) begin
            n_fail++;
            $display("FAIL div_tag: got %0d expected 3", t);
        end
        issue(OP_REM, -64'sd7, 64'd2, 5'd4, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_result: got %h expected ffffffffffffffff", r);
        end
        issue(OP_DIVU, 64'd100, 64'd7, 5'd5, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'd14) begin
            n_fail++;
            $display("FAIL divu_result: got %h expected e", r);
        end
    endtask

    task automatic test_div_by_zero();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_DIVU, 64'h1234, 64'd0, 5'd7, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL divz_result: got %h expected ffffffffffffffff", r);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL divz_latency: got %0d expected 1", lat);
        end
        issue(OP_REMU, 64'h1234, 64'd0, 5'd8, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'h1234) begin
            n_fail++;
            $display("FAIL remz_result: got %h expected 1234", r);
        end
    endtask

    task automatic test_overflow();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_DIV, 64'h8000_0000_0000_0000, '1, 5'd9, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL ovf_div: got %h expected 8000000000000000", r);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL ovf_latency: got %0d expected 1", lat);
        end
        issue(OP_REM, 64'h8000_0000_0000_0000, '1, 5'd10, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'd0) begin
            n_fail++;
            $display("FAIL ovf_rem: got %h expected 0", r);
        end
    endtask

    task automatic test_mul();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_MULHU, '1, '1, 5'd11, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL mulhu: got %h expected fffffffffffffffe", r);
        end
        n_checks++;
        if (lat !== 65) begin
            n_fail++;
            $display("FAIL mulhu_latency: got %0d expected 65", lat);
        end
        issue(OP_MULH, '1, '1, 5'd12, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'd0) begin
            n_fail++;
            $display("FAIL mulh: got %h expected 0", r);
        end
        issue(OP_MULHSU, '1, 64'd2, 5'd13, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL mulhsu: got %h expected ffffffffffffffff", r);
        end
        issue(OP_MUL, 64'd3, -64'sd5, 5'd14, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            n_fail++;
            $display("FAIL mul: got %h expected fffffffffffffff1", r);
        end
    endtask

    task automatic test_word();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_MULW, 64'h7FFF_FFFF, 64'd2, 5'd15, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL mulw: got %h expected fffffffffffffffe", r);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL mulw_latency: got %0d expected 33", lat);
        end
        issue(OP_DIVW, 64'h0000_0001_8000_0000, '1, 5'd16, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_8000_0000) begin
            n_fail++;
            $display("FAIL divw_ovf: got %h expected ffffffff80000000", r);
        end
        issue(OP_DIVUW, 64'hABCD_0000_FFFF_FFFF, 64'd1, 5'd17, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL divuw: got %h expected ffffffffffffffff", r);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL divuw_latency: got %0d expected 33", lat);
        end
        issue(OP_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd18, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL remw: got %h expected ffffffffffffffff", r);
        end
    endtask

    task automatic test_handshake_hold();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(OP_DIVU, 64'd50, 64'd5, 5'd21, 1'b0, r, t, il, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== 64'd10 || out_tag !== 5'd21) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b r=%h t=%0d expected v=1 r=a t=21",
                         out_valid, out_result, out_tag);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_in_ready: got %b expected 0", in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b rdy=%b expected v=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_DIV;
        in_a     = 64'd1000;
        in_b     = 64'd3;
        in_tag   = 5'd22;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_tag   = 5'd23;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid)
                seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_output: got out_valid rise expected none");
        end
        issue(OP_DIVU, 64'd100, 64'd7, 5'd24, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'd14 || t !== 5'd24 || lat !== 65) begin
            n_fail++;
            $display("FAIL flush_next: got r=%h t=%0d lat=%0d expected r=e t=24 lat=65",
                     r, t, lat);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_MULHU;
        in_a     = 64'd5;
        in_b     = 64'd6;
        in_tag   = 5'd25;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b rdy=%b t=%0d expected v=0 rdy=1 t=0",
                     out_valid, in_ready, out_tag);
        end
        @(negedge clk);
        reset_n = 1'b1;
        issue(OP_REMU, 64'd100, 64'd7, 5'd26, 1'b1, r, t, il, lat);
        n_checks++;
        if (r !== 64'd2 || t !== 5'd26) begin
            n_fail++;
            $display("FAIL reset_mid_next: got r=%h t=%0d expected r=2 t=26", r, t);
        end
    endtask

    task automatic test_illegal();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] t;
        logic il;
        int lat;
        issue(mdu_op_t'(4'd14), 64'd9, 64'd9, 5'd27, 1'b1, r, t, il, lat);
        n_checks++;
        if (il !== 1'b1 || r !== '0) begin
            n_fail++;
            $display("FAIL illegal_op: got ill=%b r=%h expected ill=1 r=0", il, r);
        end
        n_checks++;
        if (lat !== 1 || t !== 5'd27) begin
            n_fail++;
            $display("FAIL illegal_latency: got lat=%0d t=%0d expected lat=1 t=27", lat, t);
        end
        issue(OP_MUL, 64'd6, 64'd7, 5'd28, 1'b1, r, t, il, lat);
        n_checks++;
        if (il !== 1'b0 || r !== 64'd42) begin
            n_fail++;
            $display("FAIL after_illegal: got ill=%b r=%h expected ill=0 r=2a", il, r);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_MUL;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_div();
        test_div_by_zero();
        test_overflow();
        test_mul();
        test_word();
        test_handshake_hold();
        test_flush();
        test_reset_mid_calc();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
